l1_mem_arbiter: RTL and testbench

//  Shares the single main-memory block port between the I-cache and D-cache miss controllers.

---
 rtl/l1_mem_arbiter_pkg.sv | 33 +++
 rtl/l1_mem_arbiter_rr_pick2.sv | 22 ++
 rtl/l1_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_l1_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types for the L1 memory arbiter: state encodings, requester IDs, bus widths.
// Widths follow the cache-wide block address/data constants.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 26
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

package l1_mem_arbiter_pkg;

  localparam int ARB_ADDR_W     = `DMEM_BLOCK_ADDR_SIZE;
  localparam int ARB_BLOCK_BITS = `DBLOCK_SIZE_BITS;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_GNT_I   = 3'd1,
    ARB_GNT_DRD = 3'd2,
    ARB_GNT_DWR = 3'd3,
    ARB_RELEASE = 3'd4
  } arb_state_e;

  // Bit positions in the two-wide request/grant vectors
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  function automatic logic arb_is_d_grant(arb_state_e s);
    return (s == ARB_GNT_DRD) || (s == ARB_GNT_DWR);
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_rr_pick2.sv
// Two-input round-robin picker: on contention the side that did not win last time is chosen.
// Purely combinational, one-hot (or zero) grant.
module rr_pick2
  import l1_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      if (last == REQ_I) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one main-memory block port between the I-cache and D-cache miss controllers.
// Grant registers one cycle after request; held until the memory done pulse, then a RELEASE gap.
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int BLOCK_BITS = ARB_BLOCK_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_memRen,
  input  logic [ADDR_W-1:0]     i_BlockAddr,
  output logic                  i_memReadReady,
  output logic [BLOCK_BITS-1:0] i_memDout,
  input  logic                  d_memRen,
  input  logic                  d_memWen,
  input  logic [ADDR_W-1:0]     d_BlockAddr,
  input  logic [BLOCK_BITS-1:0] d_memDin,
  output logic                  d_memReadReady,
  output logic                  d_memWriteDone,
  output logic [BLOCK_BITS-1:0] d_memDout,
  output logic                  memRen,
  output logic                  memWen,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [BLOCK_BITS-1:0] memDin,
  input  logic                  memReadReady,
  input  logic                  memWriteDone,
  input  logic [BLOCK_BITS-1:0] memDout
);

  arb_state_e state_q, state_d;
  req_id_e    last_q, last_d;
  logic [1:0] req;
  logic [1:0] pick;

  assign req[REQ_I] = i_memRen;
  assign req[REQ_D] = d_memRen | d_memWen;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q  <= REQ_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick[REQ_I]) begin
          state_d = ARB_GNT_I;
        end else if (pick[REQ_D]) begin
          // A simultaneous read+write level from the D side is serviced as the writeback
          state_d = d_memWen ? ARB_GNT_DWR : ARB_GNT_DRD;
        end
      end
      ARB_GNT_I: begin
        if (memReadReady) begin
          state_d = ARB_RELEASE;
          last_d  = REQ_I;
        end
      end
      ARB_GNT_DRD: begin
        if (memReadReady) begin
          state_d = ARB_RELEASE;
          last_d  = REQ_D;
        end
      end
      ARB_GNT_DWR: begin
        if (memWriteDone) begin
          state_d = ARB_RELEASE;
          last_d  = REQ_D;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Enables depend only on registered state; addresses/data pass through from the granted side
  always_comb begin
    memRen  = 1'b0;
    memWen  = 1'b0;
    memAddr = '0;
    memDin  = '0;
    case (state_q)
      ARB_GNT_I: begin
        memRen  = 1'b1;
        memAddr = i_BlockAddr;
      end
      ARB_GNT_DRD: begin
        memRen  = 1'b1;
        memAddr = d_BlockAddr;
        memDin  = d_memDin;
      end
      ARB_GNT_DWR: begin
        memWen  = 1'b1;
        memAddr = d_BlockAddr;
        memDin  = d_memDin;
      end
      default: begin
        memRen = 1'b0;
      end
    endcase
  end

  // Done pulses outside the matching grant state are dropped here
  assign i_memReadReady = (state_q == ARB_GNT_I)   & memReadReady;
  assign d_memReadReady = (state_q == ARB_GNT_DRD) & memReadReady;
  assign d_memWriteDone = (state_q == ARB_GNT_DWR) & memWriteDone;

  assign i_memDout = memDout;
  assign d_memDout = memDout;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  localparam int AW = 26;
  localparam int BW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_memRen = 1'b0;
  logic [AW-1:0] i_BlockAddr = '0;
  logic          i_memReadReady;
  logic [BW-1:0] i_memDout;
  logic          d_memRen = 1'b0;
  logic          d_memWen = 1'b0;
  logic [AW-1:0] d_BlockAddr = '0;
  logic [BW-1:0] d_memDin = '0;
  logic          d_memReadReady;
  logic          d_memWriteDone;
  logic [BW-1:0] d_memDout;
  logic          memRen;
  logic          memWen;
  logic [AW-1:0] memAddr;
  logic [BW-1:0] memDin;
  logic          memReadReady = 1'b0;
  logic          memWriteDone = 1'b0;
  logic [BW-1:0] memDout = '0;

  l1_mem_arbiter #(.ADDR_W(AW), .BLOCK_BITS(BW)) dut (
    .clock(clock), .reset(reset),
    .i_memRen(i_memRen), .i_BlockAddr(i_BlockAddr),
    .i_memReadReady(i_memReadReady), .i_memDout(i_memDout),
    .d_memRen(d_memRen), .d_memWen(d_memWen), .d_BlockAddr(d_BlockAddr),
    .d_memDin(d_memDin), .d_memReadReady(d_memReadReady),
    .d_memWriteDone(d_memWriteDone), .d_memDout(d_memDout),
    .memRen(memRen), .memWen(memWen), .memAddr(memAddr), .memDin(memDin),
    .memReadReady(memReadReady), .memWriteDone(memWriteDone), .memDout(memDout)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    i_memRen = 0; d_memRen = 0; d_memWen = 0;
    memReadReady = 0; memWriteDone = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  function automatic logic [BW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: who owns the memory port, written in transaction terms
  localparam int O_NONE = 0, O_I = 1, O_DRD = 2, O_DWR = 3, O_GAP = 4;
  int            m_own;
  bit            m_last_d;
  int            m_cnt;
  bit            i_pend, d_pend, i_done, d_done;
  int            i_wait, d_wait;
  bit            req_i, req_d, d_side;
  logic          e_ren, e_wen, e_irr, e_drr, e_dwd;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_din;
  logic [BW-1:0] blk;

  initial begin
    // Reset state
    #2;
    chk("rst_memRen", memRen, 0);
    chk("rst_memWen", memWen, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memDin", memDin, 0);
    chk("rst_dones", {i_memReadReady, d_memReadReady, d_memWriteDone}, 0);
    @(negedge clock);
    reset = 1;

    // 1: lone I read
    @(negedge clock);
    i_memRen = 1; i_BlockAddr = 26'h0000A5;
    #1 chk("t1_no_comb_path", memRen, 0);
    @(negedge clock); #1;
    chk("t1_memRen", memRen, 1);
    chk("t1_memAddr", memAddr, 26'h0000A5);
    blk = rand_blk();
    memReadReady = 1; memDout = blk;
    #1;
    chk("t1_i_rr", i_memReadReady, 1);
    chk("t1_d_rr", d_memReadReady, 0);
    chk("t1_i_dout", i_memDout, blk);
    @(negedge clock);
    memReadReady = 0; i_memRen = 0;
    #1 chk("t1_release", dut.state_q, ARB_RELEASE);
    chk("t1_rel_ren", memRen, 0);
    @(negedge clock); #1 chk("t1_idle", dut.state_q, ARB_IDLE);

    // 2: simultaneous I and D reads after reset -> I first, then D
    do_reset();
    i_memRen = 1; i_BlockAddr = 26'h111;
    d_memRen = 1; d_BlockAddr = 26'h222;
    @(negedge clock); #1;
    chk("t2_i_first_ren", memRen, 1);
    chk("t2_i_first_addr", memAddr, 26'h111);
    memReadReady = 1; #1;
    chk("t2_i_rr", i_memReadReady, 1);
    chk("t2_d_rr_quiet", d_memReadReady, 0);
    @(negedge clock);
    memReadReady = 0; i_memRen = 0;
    #1 chk("t2_rel_ren", memRen, 0);
    chk("t2_rel_state", dut.state_q, ARB_RELEASE);
    @(negedge clock); #1 chk("t2_idle_ren", memRen, 0);
    @(negedge clock); #1;
    chk("t2_d_ren", memRen, 1);
    chk("t2_d_addr", memAddr, 26'h222);
    memReadReady = 1; #1;
    chk("t2_d_rr", d_memReadReady, 1);
    chk("t2_i_rr_quiet", i_memReadReady, 0);
    @(negedge clock);
    memReadReady = 0; d_memRen = 0;
    #1 chk("t2_d_rel_ren", memRen, 0);
    @(negedge clock);

    // 3: D writeback, with stray read-ready (4), then a D read regranted after RELEASE
    d_memWen = 1; d_BlockAddr = 26'h10;
    d_memDin = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    @(negedge clock); #1;
    chk("t3_wen", memWen, 1);
    chk("t3_ren_off", memRen, 0);
    chk("t3_addr", memAddr, 26'h10);
    chk("t3_din", memDin, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    memReadReady = 1; #1;
    chk("t4_stray_d_rr", d_memReadReady, 0);
    chk("t4_stray_i_rr", i_memReadReady, 0);
    @(negedge clock);
    memReadReady = 0;
    #1 chk("t4_still_dwr", dut.state_q, ARB_GNT_DWR);
    memWriteDone = 1; #1;
    chk("t3_wdone", d_memWriteDone, 1);
    @(negedge clock);
    memWriteDone = 0; d_memWen = 0; d_memRen = 1; d_BlockAddr = 26'h20;
    #1 chk("t3_rel_state", dut.state_q, ARB_RELEASE);
    chk("t3_rel_en", {memRen, memWen}, 0);
    @(negedge clock); #1 chk("t3_idle", dut.state_q, ARB_IDLE);
    @(negedge clock); #1;
    chk("t3_d_regrant", dut.state_q, ARB_GNT_DRD);
    chk("t3_d_regrant_addr", memAddr, 26'h20);

    // 5: reset mid-grant
    #2 reset = 0;
    #1;
    chk("t5_async_ren", memRen, 0);
    chk("t5_async_state", dut.state_q, ARB_IDLE);
    clr_inputs();
    @(negedge clock);
    reset = 1;
    @(negedge clock); #1;
    chk("t5_post_idle", dut.state_q, ARB_IDLE);
    chk("t5_post_ren", memRen, 0);

    // 6: randomized stress
    m_own = O_NONE; m_last_d = 1; m_cnt = 0;
    i_pend = 0; d_pend = 0; i_done = 0; d_done = 0; i_wait = 0; d_wait = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clock);
      if (i_done) begin
        i_memRen = 0; i_pend = 0; i_done = 0;
      end else if (!i_pend && $urandom_range(3) == 0) begin
        i_pend = 1; i_memRen = 1; i_BlockAddr = AW'($urandom);
      end
      if (d_done) begin
        d_memRen = 0; d_memWen = 0; d_pend = 0; d_done = 0;
      end else if (!d_pend && $urandom_range(3) == 0) begin
        d_pend = 1;
        case ($urandom_range(2))
          0:       begin d_memRen = 1; d_memWen = 0; end
          1:       begin d_memRen = 0; d_memWen = 1; end
          default: begin d_memRen = 1; d_memWen = 1; end
        endcase
        d_BlockAddr = AW'($urandom);
        d_memDin = rand_blk();
      end
      memReadReady = 0; memWriteDone = 0; memDout = rand_blk();
      if (m_own == O_I || m_own == O_DRD || m_own == O_DWR) begin
        if (m_cnt == 0) begin
          if (m_own == O_DWR) memWriteDone = 1; else memReadReady = 1;
        end else begin
          m_cnt--;
          if ($urandom_range(7) == 0) begin
            if (m_own == O_DWR) memReadReady = 1; else memWriteDone = 1;
          end
        end
      end else if ($urandom_range(7) == 0) begin
        if ($urandom_range(1) == 0) memReadReady = 1; else memWriteDone = 1;
      end
      #1;
      e_ren  = (m_own == O_I) || (m_own == O_DRD);
      e_wen  = (m_own == O_DWR);
      e_addr = (m_own == O_I) ? i_BlockAddr :
               (m_own == O_DRD || m_own == O_DWR) ? d_BlockAddr : '0;
      e_din  = (m_own == O_DRD || m_own == O_DWR) ? d_memDin : '0;
      e_irr  = (m_own == O_I) && memReadReady;
      e_drr  = (m_own == O_DRD) && memReadReady;
      e_dwd  = (m_own == O_DWR) && memWriteDone;
      chk("st_memRen", memRen, e_ren);
      chk("st_memWen", memWen, e_wen);
      chk("st_memAddr", memAddr, e_addr);
      chk("st_memDin", memDin, e_din);
      chk("st_i_rr", i_memReadReady, e_irr);
      chk("st_d_rr", d_memReadReady, e_drr);
      chk("st_d_wd", d_memWriteDone, e_dwd);
      chk("st_i_dout", i_memDout, memDout);
      chk("st_d_dout", d_memDout, memDout);

      case (m_own)
        O_NONE: begin
          req_i = i_memRen;
          req_d = d_memRen | d_memWen;
          if (req_i || req_d) begin
            d_side = req_d && (!req_i || !m_last_d);
            m_cnt = $urandom_range(3);
            if (d_side) begin
              chk("st_starve_d", d_wait <= 1, 1);
              d_wait = 0;
              if (req_i) i_wait++;
              m_own = d_memWen ? O_DWR : O_DRD;
            end else begin
              chk("st_starve_i", i_wait <= 1, 1);
              i_wait = 0;
              if (req_d) d_wait++;
              m_own = O_I;
            end
          end
        end
        O_I:   if (memReadReady) begin m_own = O_GAP; m_last_d = 0; i_done = 1; end
        O_DRD: if (memReadReady) begin m_own = O_GAP; m_last_d = 1; d_done = 1; end
        O_DWR: if (memWriteDone) begin m_own = O_GAP; m_last_d = 1; d_done = 1; end
        default: m_own = O_NONE;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
